// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, aligns/extends SRAM load
// data through a one-entry hold buffer, and drives the write-back and forwarding buses.
// Optional MEM_ALIGN_CHECK_EN adds the mem_adel misaligned-access flag.
module mem_stage #(
  parameter int EX_MEM_W = 212,
  parameter int MEM_WB_W = 136,
  parameter int MEM_ID_W = 104
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic [EX_MEM_W-1:0] ex_to_mem_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic [MEM_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_ID_W-1:0] mem_to_id_bus
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                mem_adel
`endif
);

  logic [EX_MEM_W-1:0] bus_q, bus_d;
  logic                held_q, held_d;
  logic [31:0]         rbuf_q, rbuf_d;

  logic capture, bubble, hold;
  logic unused_stall;

  assign capture      = ~stall[3];
  assign bubble       = stall[3] & ~stall[4];
  assign hold         = stall[3] & stall[4];
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Field views of the registered execute bus
  logic        inst_h, inst_hu, inst_b, inst_bu;
  logic        hi_we, lo_we, r_lo, r_hi;
  logic [31:0] hi_wdata, lo_wdata, r_lo_data, r_hi_data, pc, ex_result;
  logic        data_ram_en, sel_rf_res, rf_we;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign {inst_h, inst_hu, inst_b, inst_bu,
          hi_we, hi_wdata, lo_we, lo_wdata,
          r_lo, r_lo_data, r_hi, r_hi_data, pc,
          data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = bus_q;

  logic        is_load;
  logic [1:0]  a;
  logic [31:0] raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        rf_we_out;

  assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;
  assign a       = ex_result[1:0];
  assign raw     = held_q ? rbuf_q : data_sram_rdata;

  always_comb begin
    byte_sel = raw[7:0];
    case (a)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = a[1] ? raw[31:16] : raw[15:0];

    load_data = raw;
    if (inst_b)       load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (inst_bu) load_data = {24'h0, byte_sel};
    else if (inst_h)  load_data = {{16{half_sel[15]}}, half_sel};
    else if (inst_hu) load_data = {16'h0, half_sel};
  end

  always_comb begin
    rf_wdata = ex_result;
    if (is_load)   rf_wdata = load_data;
    else if (r_hi) rf_wdata = r_hi_data;
    else if (r_lo) rf_wdata = r_lo_data;
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic half_acc, word_acc;
  assign half_acc  = inst_h | inst_hu;
  assign word_acc  = ~(inst_h | inst_hu | inst_b | inst_bu);
  assign mem_adel  = data_ram_en & ((half_acc & a[0]) | (word_acc & (a != 2'd0)));
  assign rf_we_out = rf_we & ~(mem_adel & is_load);
`else
  assign rf_we_out = rf_we;
`endif

  assign mem_to_wb_bus = {hi_we, hi_wdata, lo_we, lo_wdata, pc, rf_we_out, rf_waddr, rf_wdata};
  assign mem_to_id_bus = {hi_we, hi_wdata, lo_we, lo_wdata, rf_we_out, rf_waddr, rf_wdata};

  // The hold buffer snapshots SRAM data on the first stalled edge so the load keeps its value
  always_comb begin
    bus_d  = bus_q;
    held_d = held_q;
    rbuf_d = rbuf_q;
    if (bubble) begin
      bus_d  = '0;
      held_d = 1'b0;
    end else if (capture) begin
      bus_d  = ex_to_mem_bus;
      held_d = 1'b0;
    end else if (hold && !held_q) begin
      rbuf_d = data_sram_rdata;
      held_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q  <= '0;
      held_q <= 1'b0;
      rbuf_q <= '0;
    end else begin
      bus_q  <= bus_d;
      held_q <= held_d;
      rbuf_q <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: vector table plus stall/bubble/reset sequences.
// Checks mem_adel as well when built with MEM_ALIGN_CHECK_EN.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [211:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_id_bus;
`ifdef MEM_ALIGN_CHECK_EN
  logic         mem_adel;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_adel        (mem_adel)
`endif
  );

  localparam logic [3:0] SZ_W  = 4'b0000;
  localparam logic [3:0] SZ_H  = 4'b1000;
  localparam logic [3:0] SZ_HU = 4'b0100;
  localparam logic [3:0] SZ_B  = 4'b0010;
  localparam logic [3:0] SZ_BU = 4'b0001;

  // sz = {inst_h, inst_hu, inst_b, inst_bu}; hi/lo/pc/waddr are fixed recognisable values
  function automatic logic [211:0] mk(input logic [3:0] sz, input logic en, input logic [3:0] wen,
                                      input logic sel, input logic rfwe, input logic rhi,
                                      input logic [31:0] rhid, input logic rlo,
                                      input logic [31:0] rlod, input logic [31:0] ex);
    return {sz, 1'b1, 32'hA000_0001, 1'b1, 32'hB000_0002, rlo, rlod, rhi, rhid,
            32'h8000_0100, en, wen, sel, rfwe, 5'd9, ex};
  endfunction

  function automatic logic [135:0] exp_wb(input logic [211:0] b, input logic [31:0] wd);
    return {b[207:142], b[75:44], b[37], b[36:32], wd};
  endfunction

  function automatic logic [103:0] exp_id(input logic [211:0] b, input logic [31:0] wd);
    return {b[207:142], b[37], b[36:32], wd};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [211:0] bus;
    logic [31:0]  rdata;
    logic [31:0]  wd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{mk(SZ_B,  1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_1003), 32'h8011_2233, 32'hFFFF_FF80};
    vecs[1]  = '{mk(SZ_BU, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_1003), 32'h8011_2233, 32'h0000_0080};
    vecs[2]  = '{mk(SZ_H,  1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0002), 32'h9ABC_1234, 32'hFFFF_9ABC};
    vecs[3]  = '{mk(SZ_HU, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0000), 32'h9ABC_1234, 32'h0000_1234};
    vecs[4]  = '{mk(SZ_W,  1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0000), 32'h9ABC_1234, 32'h9ABC_1234};
    vecs[5]  = '{mk(SZ_W,  0, 4'h0, 0, 1, 1, 32'h1234_5678, 0, 0, 32'h0000_0005), 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[6]  = '{mk(SZ_W,  0, 4'h0, 0, 1, 0, 0, 1, 32'hCAFE_F00D, 32'h0000_0007), 32'h0, 32'hCAFE_F00D};
    vecs[7]  = '{mk(SZ_W,  0, 4'h0, 0, 1, 0, 0, 0, 0, 32'hA5A5_A5A5), 32'h1111_1111, 32'hA5A5_A5A5};
    vecs[8]  = '{mk(SZ_B,  1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0001), 32'h0000_7F00, 32'h0000_007F};
    vecs[9]  = '{mk(SZ_BU, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0002), 32'h00FF_0000, 32'h0000_00FF};
    vecs[10] = '{mk(SZ_H,  1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0000), 32'h0000_8001, 32'hFFFF_8001};
    // store: result is the address, write enable stays as supplied (0)
    vecs[11] = '{mk(SZ_W,  1, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0000_0100), 32'h7777_7777, 32'h0000_0100};
    // load wins over r_hi
    vecs[12] = '{mk(SZ_BU, 1, 4'h0, 1, 1, 1, 32'h1234_5678, 0, 0, 32'h0000_0000), 32'h0000_00C3, 32'h0000_00C3};
  end

  logic [211:0] b;

  initial begin
    rst             = 1'b1;
    stall           = 6'b0;
    ex_to_mem_bus   = '0;
    data_sram_rdata = 32'hFFFF_FFFF;
    #12;
    chk("reset_wb", mem_to_wb_bus, '0);
    chk("reset_id", {32'h0, mem_to_id_bus}, '0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      ex_to_mem_bus   = vecs[i].bus;
      data_sram_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("vec%0d_wb", i), mem_to_wb_bus, exp_wb(vecs[i].bus, vecs[i].wd));
      chk($sformatf("vec%0d_id", i), {32'h0, mem_to_id_bus}, {32'h0, exp_id(vecs[i].bus, vecs[i].wd)});
    end

    // load stalled in this stage keeps its first-cycle data
    b = mk(SZ_W, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0040);
    ex_to_mem_bus   = b;
    data_sram_rdata = 32'hDEAD_BEEF;
    tick();
    chk("stall_c0", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'hDEAD_BEEF});
    stall         = 6'b011111;
    ex_to_mem_bus = mk(SZ_W, 0, 4'h0, 0, 1, 0, 0, 0, 0, 32'h0000_0055);
    for (int c = 1; c <= 3; c++) begin
      tick();
      data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("stall_c%0d", c), mem_to_wb_bus, exp_wb(b, 32'hDEAD_BEEF));
    end
    stall = 6'b0;
    tick();
    chk("release_alu", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h0000_0055});
    b = mk(SZ_W, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0000);
    ex_to_mem_bus   = b;
    data_sram_rdata = 32'h1111_2222;
    tick();
    chk("held_cleared", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h1111_2222});

    // bubble: stage stalled, write-back running
    b = mk(SZ_W, 0, 4'h0, 0, 1, 0, 0, 0, 0, 32'h0000_0123);
    ex_to_mem_bus = b;
    tick();
    chk("pre_bubble", mem_to_wb_bus, exp_wb(b, 32'h0000_0123));
    stall = 6'b001000;
    tick();
    chk("bubble_wb", mem_to_wb_bus, '0);
    chk("bubble_id", {32'h0, mem_to_id_bus}, '0);

    // asynchronous reset while a load is held
    stall = 6'b0;
    b = mk(SZ_W, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0004);
    ex_to_mem_bus   = b;
    data_sram_rdata = 32'hAAAA_5555;
    tick();
    stall = 6'b011111;
    tick();
    data_sram_rdata = 32'h0F0F_0F0F;
    #2;
    chk("pre_reset", mem_to_wb_bus, exp_wb(b, 32'hAAAA_5555));
    rst = 1'b1;
    #1;
    chk("async_reset_wb", mem_to_wb_bus, '0);
    chk("async_reset_id", {32'h0, mem_to_id_bus}, '0);
    #1;
    rst   = 1'b0;
    stall = 6'b0;
    tick();
    chk("post_reset_held", {104'h0, mem_to_wb_bus[31:0]}, {104'h0, 32'h0F0F_0F0F});

`ifdef MEM_ALIGN_CHECK_EN
    ex_to_mem_bus   = mk(SZ_W, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0002);
    data_sram_rdata = 32'h1234_5678;
    tick();
    chk("adel_lw", {135'h0, mem_adel}, {135'h0, 1'b1});
    chk("adel_rfwe", {135'h0, mem_to_wb_bus[37]}, {135'h0, 1'b0});
    ex_to_mem_bus = mk(SZ_H, 1, 4'h0, 1, 1, 0, 0, 0, 0, 32'h0000_0002);
    tick();
    chk("adel_lh_ok", {135'h0, mem_adel}, {135'h0, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
